// File: rtl/stn2tft_pkg.sv
// Shared constants, FSM encoding and nibble packing for the STN capture front end.
package stn2tft_pkg;

  localparam int unsigned ADDR_W_DEF    = 7;
  localparam int unsigned MAX_BYTES_DEF = 80;
  localparam int unsigned LINE_W_DEF    = 8;

  // First nibble shifted in lands in the high half of the byte (leftmost pixel in [7:4]).
  localparam bit NIB_FIRST_HIGH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  // Combine two nibbles in shift order into one byte.
  function automatic logic [7:0] pack_nib(input logic [3:0] first, input logic [3:0] second);
    return NIB_FIRST_HIGH ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/stn_sync.sv
// Two-flop synchroniser with a history flop; level is stage 2, edges compare stages 2 and 3.
module stn_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise_c,
  output logic [W-1:0] fall_c
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  // Synchroniser chain plus history stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl    = s2;
  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

endmodule

// File: rtl/stn_capture.sv
// STN panel bus capture: packs pixel nibbles into bytes and fills a ping-pong line buffer.
module stn_capture
  import stn2tft_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEF,
  parameter int unsigned LINE_W    = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              fpframe,
  input  logic              fpline,
  input  logic              fpshift,
  input  logic [3:0]        fpdat,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_dat,
  output logic              line_done,
  output logic [LINE_W-1:0] line_idx,
  output logic [ADDR_W:0]   line_bytes,
  output logic              frame_start,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_BYTES);

  logic       frame_lvl;
  logic       line_fall;
  logic       shift_fall;
  logic [3:0] dat_lvl;
  logic       frame_rise_unused, frame_fall_unused;
  logic       line_lvl_unused, line_rise_unused;
  logic       shift_lvl_unused, shift_rise_unused;
  logic [3:0] dat_rise_unused, dat_fall_unused;

  stn_sync #(.W(1)) u_sync_frame (
    .clk(clk), .rst(rst), .din(fpframe),
    .lvl(frame_lvl), .rise_c(frame_rise_unused), .fall_c(frame_fall_unused)
  );

  stn_sync #(.W(1)) u_sync_line (
    .clk(clk), .rst(rst), .din(fpline),
    .lvl(line_lvl_unused), .rise_c(line_rise_unused), .fall_c(line_fall)
  );

  stn_sync #(.W(1)) u_sync_shift (
    .clk(clk), .rst(rst), .din(fpshift),
    .lvl(shift_lvl_unused), .rise_c(shift_rise_unused), .fall_c(shift_fall)
  );

  stn_sync #(.W(4)) u_sync_dat (
    .clk(clk), .rst(rst), .din(fpdat),
    .lvl(dat_lvl), .rise_c(dat_rise_unused), .fall_c(dat_fall_unused)
  );

  cap_state_e          state_q;
  cap_state_e          state_d;
  logic                phase;
  logic [3:0]          held;
  logic [ADDR_W-1:0]   addr;
  logic [LINE_W-1:0]   line_cnt;
  logic                close_p;

  logic                fstart;
  logic                frame_hit;
  logic                shift_ev;
  logic                lend_ev;
  logic                wr_req;
  logic                wr_ok;
  logic [7:0]          wr_val;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus per-cycle event qualification and write selection.
  always_comb begin
    state_d   = state_q;
    fstart    = line_fall & frame_lvl;
    frame_hit = 1'b0;
    shift_ev  = 1'b0;
    lend_ev   = 1'b0;
    wr_req    = 1'b0;
    wr_val    = 8'h00;
    wr_ok     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (fstart) begin
          state_d   = ST_ACTIVE;
          frame_hit = 1'b1;
        end
      end
      ST_ACTIVE: begin
        frame_hit = fstart;
        shift_ev  = shift_fall & ~fstart;
        lend_ev   = line_fall & ~fstart;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!cap_en) begin
      state_d   = ST_IDLE;
      frame_hit = 1'b0;
      shift_ev  = 1'b0;
      lend_ev   = 1'b0;
    end

    // At most one byte per cycle: a completed pair, or the odd-nibble flush at line end.
    if (shift_ev && phase) begin
      wr_req = 1'b1;
      wr_val = pack_nib(held, dat_lvl);
    end else if (shift_ev && lend_ev) begin
      wr_req = 1'b1;
      wr_val = pack_nib(dat_lvl, 4'h0);
    end else if (lend_ev && phase) begin
      wr_req = 1'b1;
      wr_val = pack_nib(held, 4'h0);
    end

    wr_ok = wr_req && (addr != ADDR_MAX);
  end

  // Capture datapath: writes, line close one cycle after line end, frame restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      wr_dat      <= 8'h00;
      line_done   <= 1'b0;
      line_idx    <= '0;
      line_bytes  <= '0;
      frame_start <= 1'b0;
      ovf         <= 1'b0;
      phase       <= 1'b0;
      held        <= 4'h0;
      addr        <= '0;
      line_cnt    <= '0;
      close_p     <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      line_done   <= 1'b0;
      frame_start <= 1'b0;

      if (!cap_en) begin
        close_p <= 1'b0;
      end else if (frame_hit) begin
        frame_start <= 1'b1;
        line_cnt    <= '0;
        wr_bank     <= 1'b0;
        ovf         <= 1'b0;
        addr        <= '0;
        phase       <= 1'b0;
        close_p     <= 1'b0;
      end else begin
        if (close_p) begin
          line_done <= 1'b1;
          wr_bank   <= ~wr_bank;
          line_cnt  <= line_cnt + LINE_W'(1);
          close_p   <= 1'b0;
        end
        if (wr_ok) begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_dat  <= wr_val;
          addr    <= addr + ADDR_W'(1);
        end
        if (wr_req && !wr_ok) begin
          ovf <= 1'b1;
        end
        if (shift_ev) begin
          phase <= ~phase;
          if (!phase) held <= dat_lvl;
        end
        if (lend_ev) begin
          phase      <= 1'b0;
          addr       <= '0;
          close_p    <= 1'b1;
          line_idx   <= line_cnt;
          line_bytes <= (ADDR_W+1)'(addr) + (ADDR_W+1)'(wr_ok);
        end
      end
    end
  end

endmodule

// File: tb/tb_stn_capture.sv
// Bench for stn_capture: table-driven lines, corner sequences and randomized lines vs a line-level model.
module tb_stn_capture;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned MAXB   = 4;
  localparam int unsigned LINE_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cap_en;
  logic              fpframe;
  logic              fpline;
  logic              fpshift;
  logic [3:0]        fpdat;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_dat;
  logic              line_done;
  logic [LINE_W-1:0] line_idx;
  logic [ADDR_W:0]   line_bytes;
  logic              frame_start;
  logic              ovf;

  always #5 clk = ~clk;

  stn_capture #(.ADDR_W(ADDR_W), .MAX_BYTES(MAXB), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en),
    .fpframe(fpframe), .fpline(fpline), .fpshift(fpshift), .fpdat(fpdat),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .line_done(line_done), .line_idx(line_idx), .line_bytes(line_bytes),
    .frame_start(frame_start), .ovf(ovf)
  );

  typedef struct {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dat;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [LINE_W-1:0] idx;
    logic [ADDR_W:0]   bytes;
    int                cyc;
  } ld_t;

  typedef struct {
    int          nnib;
    logic [3:0]  base;
    int          exp_idx;
    int          exp_bank;
    int          exp_bytes;
    int          exp_ovf;
  } vec_t;

  wr_t        wq[$];
  ld_t        lq[$];
  logic [3:0] cur_nib[$];
  int         fs_cnt = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en)       wq.push_back('{wr_bank, wr_addr, wr_dat, cyc});
    if (line_done)   lq.push_back('{line_idx, line_bytes, cyc});
    if (frame_start) fs_cnt = fs_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic shift(input logic [3:0] d);
    fpdat   = d;
    fpshift = 1'b1;
    tick(3);
    fpshift = 1'b0;
    tick(3);
    cur_nib.push_back(d);
  endtask

  task automatic shift_lend(input logic [3:0] d);
    fpdat   = d;
    fpshift = 1'b1;
    fpline  = 1'b1;
    tick(3);
    fpshift = 1'b0;
    fpline  = 1'b0;
    tick(6);
    cur_nib.push_back(d);
  endtask

  task automatic lpulse(input logic frm);
    fpframe = frm;
    fpline  = 1'b1;
    tick(3);
    fpline  = 1'b0;
    tick(4);
    fpframe = 1'b0;
    tick(2);
  endtask

  // Frame lock: one frame_start, no writes, no line close, ovf cleared.
  task automatic frame_lock();
    int f0;
    f0 = fs_cnt;
    lpulse(1'b1);
    chk("frame_start_cnt", 32'(fs_cnt - f0), 32'd1);
    chk("lock_no_wr", 32'(wq.size()), 32'd0);
    chk("lock_no_line_done", 32'(lq.size()), 32'd0);
    chk("lock_ovf_clear", 32'(ovf), 32'd0);
    wq.delete();
    lq.delete();
    cur_nib.delete();
  endtask

  // Compare the writes and the line close of one line against the nibbles shifted in.
  task automatic check_line(input int exp_idx, input int exp_bank, input int exp_bytes, input int exp_ovf);
    int n, nb, nw;
    logic [3:0] hi, lo;
    n  = cur_nib.size();
    nb = (n + 1) / 2;
    nw = (nb > int'(MAXB)) ? int'(MAXB) : nb;
    chk("wr_count", 32'(wq.size()), 32'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      hi = cur_nib[2*i];
      lo = (2*i + 1 < n) ? cur_nib[2*i+1] : 4'h0;
      chk("wr_dat", 32'(wq[i].dat), 32'({hi, lo}));
      chk("wr_addr", 32'(wq[i].addr), 32'(i));
      chk("wr_bank", 32'(wq[i].bank), 32'(exp_bank));
    end
    chk("line_done_cnt", 32'(lq.size()), 32'd1);
    if (lq.size() > 0) begin
      chk("line_idx", 32'(lq[0].idx), 32'(exp_idx));
      chk("line_bytes", 32'(lq[0].bytes), 32'(exp_bytes));
    end
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    wq.delete();
    lq.delete();
    cur_nib.delete();
  endtask

  task automatic run_line(input int n, input logic [3:0] base, input bit rnd, input bit simul);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 4'($urandom) : 4'(base + 4'(i));
      if (simul && i == n - 1) shift_lend(d);
      else                     shift(d);
    end
    if (!(simul && n > 0)) lpulse(1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    int simul_wr_cyc;
    int ridx, rovf, n, nb;
    bit sim;

    vecs[0] = '{8,  4'h1, 0, 0, 4, 0};
    vecs[1] = '{3,  4'hA, 1, 1, 2, 0};
    vecs[2] = '{0,  4'h0, 2, 0, 0, 0};
    vecs[3] = '{1,  4'h7, 3, 1, 1, 0};
    vecs[4] = '{12, 4'h3, 4, 0, 4, 1};
    vecs[5] = '{2,  4'hE, 5, 1, 1, 1};

    rst = 1'b1; cap_en = 1'b0; fpframe = 1'b0; fpline = 1'b0; fpshift = 1'b0; fpdat = 4'h0;
    tick(3);
    chk("rst_ctl", 32'({wr_en, wr_bank, line_done, frame_start, ovf}), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_dat", 32'(wr_dat), 32'd0);
    chk("rst_line_idx", 32'(line_idx), 32'd0);
    chk("rst_line_bytes", 32'(line_bytes), 32'd0);
    rst = 1'b0;
    cap_en = 1'b1;
    tick(2);

    // Shifts before any frame are ignored, then lock and capture one line.
    for (int i = 0; i < 4; i++) shift(4'h9);
    frame_lock();
    shift(4'h5); shift(4'h5); shift(4'h5); shift(4'h5);
    shift(4'h5); shift(4'h8); shift(4'h5); shift(4'h5);
    lpulse(1'b0);
    if (wq.size() > 2) chk("lock_byte2", 32'(wq[2].dat), 32'h58);
    check_line(0, 0, 4, 0);

    // Table of lines after a fresh frame start.
    frame_lock();
    foreach (vecs[k]) begin
      run_line(vecs[k].nnib, vecs[k].base, 1'b0, 1'b0);
      check_line(vecs[k].exp_idx, vecs[k].exp_bank, vecs[k].exp_bytes, vecs[k].exp_ovf);
    end

    // New frame restarts the line index, bank and clears ovf.
    frame_lock();
    run_line(2, 4'h2, 1'b0, 1'b0);
    check_line(0, 0, 1, 0);

    // Odd nibble count flushes a half-filled byte.
    shift(4'hA); shift(4'hB); shift(4'hC);
    lpulse(1'b0);
    check_line(1, 1, 2, 0);

    // SHIFT and LEND in the same cycle on phase 1.
    shift(4'hA); shift(4'hB); shift(4'hC);
    shift_lend(4'hD);
    simul_wr_cyc = (wq.size() > 0) ? wq[wq.size()-1].cyc : -100;
    if (lq.size() > 0) chk("simul_done_delay", 32'(lq[0].cyc - simul_wr_cyc), 32'd1);
    else               chk("simul_done_seen", 32'(lq.size()), 32'd1);
    check_line(2, 0, 2, 0);

    // cap_en drop mid-line: no close; SYNC afterwards discards data.
    shift(4'h1); shift(4'h2); shift(4'h3);
    cap_en = 1'b0;
    tick(1);
    chk("abort_no_done", 32'(line_done), 32'd0);
    tick(6);
    lpulse(1'b0);
    chk("abort_no_line_done", 32'(lq.size()), 32'd0);
    wq.delete(); cur_nib.delete();
    cap_en = 1'b1;
    tick(2);
    shift(4'h6); shift(4'h7);
    lpulse(1'b0);
    chk("sync_no_wr", 32'(wq.size()), 32'd0);
    chk("sync_no_line_done", 32'(lq.size()), 32'd0);

    // Reset in the middle of an overflowing line.
    frame_lock();
    for (int i = 0; i < 10; i++) shift(4'(i + 3));
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midrst_ctl", 32'({wr_en, wr_bank, line_done, frame_start, ovf}), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_dat", 32'(wr_dat), 32'd0);
    chk("midrst_line_idx", 32'(line_idx), 32'd0);
    chk("midrst_line_bytes", 32'(line_bytes), 32'd0);
    rst = 1'b0;
    tick(2);
    lpulse(1'b0);
    chk("midrst_no_line_done", 32'(lq.size()), 32'd0);
    wq.delete(); lq.delete(); cur_nib.delete();

    // Randomized lines against the line-level model.
    frame_lock();
    ridx = 0;
    rovf = 0;
    for (int l = 0; l < 16; l++) begin
      if ($urandom_range(0, 6) == 0) begin
        frame_lock();
        ridx = 0;
        rovf = 0;
      end
      n   = int'($urandom_range(0, 12));
      sim = bit'($urandom_range(0, 1));
      nb  = (n + 1) / 2;
      run_line(n, 4'h0, 1'b1, sim);
      if (nb > int'(MAXB)) rovf = 1;
      check_line(ridx % 256, ridx % 2, (nb > int'(MAXB)) ? int'(MAXB) : nb, rovf);
      ridx = ridx + 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
